// File: rtl/risc_host_loader_pkg.sv
// ============================================================================
// risc_host_pkg : shared types and constants for the my_risc host loader
// Revision 1.0
// ============================================================================
`default_nettype none

package risc_host_pkg;

    localparam int DEF_ADDR_W = 7;
    localparam int DEF_DATA_W = 16;

    // Core-port write-bar encoding
    localparam logic WRB_WRITE = 1'b0;
    localparam logic WRB_READ  = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_START   = 3'd2,
        S_RUN     = 3'd3,
        S_RD_ADDR = 3'd4,
        S_RD_WAIT = 3'd5,
        S_RD_OUT  = 3'd6,
        S_FINISH  = 3'd7
    } host_state_e;

endpackage

`default_nettype wire

// File: rtl/risc_host_loader_if.sv
// ============================================================================
// risc_host_loader_if : load stream, readback stream and core access port
// Revision 1.0
// ============================================================================
`default_nettype none

interface risc_host_loader_if
    import risc_host_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              Iwr_valid;
    logic              Owr_ready;
    logic [ADDR_W-1:0] Iwr_addr;
    logic [DATA_W-1:0] Iwr_data;
    logic              Iwr_last;

    logic              Ord_valid;
    logic              Ird_ready;
    logic [ADDR_W-1:0] Ord_addr;
    logic [DATA_W-1:0] Ord_data;

    logic              Ocpu_access;
    logic              Ocpu_wrb;
    logic [ADDR_W-1:0] Ocpu_addr;
    logic [DATA_W-1:0] Ocpu_data;
    logic              Ocpu_start;
    logic [DATA_W-1:0] Icpu_data;
    logic              Icpu_done;

    // master = the loader, slave = host/core environment
    modport master (
        input  Iwr_valid, Iwr_addr, Iwr_data, Iwr_last, Ird_ready, Icpu_data, Icpu_done,
        output Owr_ready, Ord_valid, Ord_addr, Ord_data,
        output Ocpu_access, Ocpu_wrb, Ocpu_addr, Ocpu_data, Ocpu_start
    );

    modport slave (
        output Iwr_valid, Iwr_addr, Iwr_data, Iwr_last, Ird_ready, Icpu_data, Icpu_done,
        input  Owr_ready, Ord_valid, Ord_addr, Ord_data,
        input  Ocpu_access, Ocpu_wrb, Ocpu_addr, Ocpu_data, Ocpu_start
    );

endinterface

`default_nettype wire

// File: rtl/host_run_timer.sv
// ============================================================================
// host_run_timer : RUN-phase cycle counter with done-arming and expiry flags
// Revision 1.0
// ============================================================================
`default_nettype none

module host_run_timer #(
    parameter int TIMEOUT = 1023
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic clear_i,
    input  wire logic run_i,
    output logic      armed_o,
    output logic      expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (run_i) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Armed from the second RUN cycle so a done flag left over from a previous run is ignored
    assign armed_o   = (count_q != '0);
    assign expired_o = (count_q == CNT_W'(TIMEOUT - 1));

endmodule

`default_nettype wire

// File: rtl/risc_host_loader.sv
// ============================================================================
// risc_host_loader : loads my_risc memory, runs the core, streams a result window
// Revision 1.0
// ============================================================================
`default_nettype none

module risc_host_loader
    import risc_host_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = 1023
) (
    input  wire logic              Iclk,
    input  wire logic              Ireset_n,
    input  wire logic              Igo,
    input  wire logic [ADDR_W-1:0] Idump_base,
    input  wire logic [ADDR_W:0]   Idump_len,
    risc_host_loader_if.master     bus,
    output logic                   Obusy,
    output logic                   Odone,
    output logic                   Otimeout
);

    host_state_e       state_q;
    logic              busy_q, done_q, timeout_q;
    logic              wr_ready_q;
    logic              cpu_access_q, cpu_wrb_q, cpu_start_q;
    logic [ADDR_W-1:0] cpu_addr_q;
    logic [DATA_W-1:0] cpu_data_q;
    logic              rd_valid_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W:0]   remain_q;
    logic              w_armed, w_expired;

    host_run_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk       (Iclk),
        .rst_n     (Ireset_n),
        .clear_i   (state_q == S_START),
        .run_i     (state_q == S_RUN),
        .armed_o   (w_armed),
        .expired_o (w_expired)
    );

    always_ff @(posedge Iclk or negedge Ireset_n) begin
        if (!Ireset_n) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            timeout_q    <= 1'b0;
            wr_ready_q   <= 1'b0;
            cpu_access_q <= 1'b0;
            cpu_wrb_q    <= WRB_READ;
            cpu_addr_q   <= '0;
            cpu_data_q   <= '0;
            cpu_start_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_addr_q    <= '0;
            rd_data_q    <= '0;
            ptr_q        <= '0;
            remain_q     <= '0;
        end else begin
            cpu_start_q <= 1'b0;
            done_q      <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (Igo) begin
                        state_q    <= S_LOAD;
                        busy_q     <= 1'b1;
                        wr_ready_q <= 1'b1;
                        timeout_q  <= 1'b0;
                        ptr_q      <= Idump_base;
                        remain_q   <= Idump_len;
                    end
                end
                S_LOAD: begin
                    if (wr_ready_q) begin
                        cpu_access_q <= bus.Iwr_valid;
                        if (bus.Iwr_valid) begin
                            cpu_wrb_q  <= WRB_WRITE;
                            cpu_addr_q <= bus.Iwr_addr;
                            cpu_data_q <= bus.Iwr_data;
                            wr_ready_q <= !bus.Iwr_last;
                        end else begin
                            cpu_wrb_q <= WRB_READ;
                        end
                    end else begin
                        // Ready low here means the final write is on the port this cycle
                        cpu_access_q <= 1'b0;
                        cpu_wrb_q    <= WRB_READ;
                        cpu_start_q  <= 1'b1;
                        state_q      <= S_START;
                    end
                end
                S_START: begin
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (w_armed && bus.Icpu_done) begin
                        if (remain_q != '0) begin
                            state_q      <= S_RD_ADDR;
                            cpu_access_q <= 1'b1;
                            cpu_wrb_q    <= WRB_READ;
                            cpu_addr_q   <= ptr_q;
                        end else begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end
                    end else if (w_expired) begin
                        state_q   <= S_FINISH;
                        done_q    <= 1'b1;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                    end
                end
                S_RD_ADDR: begin
                    cpu_access_q <= 1'b0;
                    state_q      <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    rd_data_q  <= bus.Icpu_data;
                    rd_addr_q  <= ptr_q;
                    rd_valid_q <= 1'b1;
                    state_q    <= S_RD_OUT;
                end
                S_RD_OUT: begin
                    if (bus.Ird_ready) begin
                        rd_valid_q <= 1'b0;
                        ptr_q      <= ptr_q + 1'b1;
                        remain_q   <= remain_q - 1'b1;
                        if (remain_q == (ADDR_W+1)'(1)) begin
                            state_q <= S_FINISH;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q      <= S_RD_ADDR;
                            cpu_access_q <= 1'b1;
                            cpu_wrb_q    <= WRB_READ;
                            cpu_addr_q   <= ptr_q + 1'b1;
                        end
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.Owr_ready   = wr_ready_q;
    assign bus.Ord_valid   = rd_valid_q;
    assign bus.Ord_addr    = rd_addr_q;
    assign bus.Ord_data    = rd_data_q;
    assign bus.Ocpu_access = cpu_access_q;
    assign bus.Ocpu_wrb    = cpu_wrb_q;
    assign bus.Ocpu_addr   = cpu_addr_q;
    assign bus.Ocpu_data   = cpu_data_q;
    assign bus.Ocpu_start  = cpu_start_q;
    assign Obusy           = busy_q;
    assign Odone           = done_q;
    assign Otimeout        = timeout_q;

endmodule

`default_nettype wire

// File: doc/risc_host_loader.md
# risc_host_loader

Host-side sequencer that drives the `my_risc` external access port. It streams a program and data image into the core's memory, pulses start, and waits for the core's done flag with a timeout. It then reads a result window back out of memory and presents it on a valid/ready stream. It replaces the hand-written load/run/readback sequence in the system-level benches, and is the on-chip front end for the core.

## Interface
- `ADDR_W`, 7: core memory address width (128 words).
- `DATA_W`, 16: core word width.
- `TIMEOUT`, 1023: maximum cycles spent in RUN before the run is aborted.
- `Iclk` in 1: single clock; all state updates on the rising edge.
- `Ireset_n` in 1: asynchronous, active-low reset.
- `Igo` in 1: session start pulse; ignored while `Obusy`=1.
- `Idump_base` in ADDR_W: first readback address; sampled on an accepted `Igo`.
- `Idump_len` in ADDR_W+1: readback word count, 0..128; sampled on an accepted `Igo`.
- `Iwr_valid` / `Owr_ready` in/out 1: load-stream handshake.
- `Iwr_addr` in ADDR_W, `Iwr_data` in DATA_W, `Iwr_last` in 1: load word payload. `Iwr_last` marks the final word.
- `Ord_valid` / `Ird_ready` out/in 1: readback-stream handshake.
- `Ord_addr` out ADDR_W, `Ord_data` out DATA_W: readback payload.
- `Ocpu_access`, `Ocpu_wrb` out 1 each: core access enable and write-bar (0 = write, 1 = read/run).
- `Ocpu_addr` out ADDR_W, `Ocpu_data` out DATA_W: core address and write data.
- `Ocpu_start` out 1: core start pulse.
- `Icpu_data` in DATA_W, `Icpu_done` in 1: core read data and halt flag.
- `Obusy`, `Odone`, `Otimeout` out 1 each: session status.

## Operation
- States: IDLE, LOAD, START, RUN, RD_ADDR, RD_WAIT, RD_OUT, FINISH.
- All outputs are registered.
- Reset values: `Ocpu_access`=0, `Ocpu_wrb`=1, `Ocpu_addr`=0, `Ocpu_data`=0, `Ocpu_start`=0, `Owr_ready`=0, `Ord_valid`=0, `Ord_addr`=0, `Ord_data`=0, `Obusy`=0, `Odone`=0, `Otimeout`=0. State resets to IDLE.
- **IDLE:** `Igo` moves to LOAD, sets `Obusy`, latches dump base/len and clears `Otimeout`.
- **LOAD:** `Owr_ready`=1. Each accepted word drives `Ocpu_access`=1, `Ocpu_wrb`=0, `Ocpu_addr`/`Ocpu_data` on the following cycle, for exactly one cycle. With no accept, `Ocpu_access`=0. An accepted `Iwr_last` deasserts `Owr_ready` and moves to START after its write cycle.
- **START:** one cycle with `Ocpu_start`=1, `Ocpu_access`=0, `Ocpu_wrb`=1. Then RUN.
- **RUN:** count cycles from 0. `Icpu_done` is sampled only from the second RUN cycle onward, so a stale done flag is not taken.
  - Done → RD_ADDR if the latched len is nonzero, else FINISH.
  - Count reaches TIMEOUT with no done → set `Otimeout`, go to FINISH, skip readback.
- **RD_ADDR:** `Ocpu_access`=1, `Ocpu_wrb`=1, `Ocpu_addr`=current address.
- **RD_WAIT:** capture `Icpu_data` into `Ord_data`, and the address into `Ord_addr`.
- **RD_OUT:** `Ord_valid`=1, held stable until `Ird_ready`. On accept, address increments modulo 2^ADDR_W (127 wraps to 0) and remaining count decrements. Remaining = 0 → FINISH, else RD_ADDR.
- **FINISH:** `Odone`=1 for one cycle, `Ocpu_access`=0, `Obusy` clears. Return to IDLE. `Otimeout` holds until the next accepted `Igo`.
- Reset asserted mid-session: immediate return to reset values. No partial write cycle may remain on the core port.

## Timing
- Load: one word per cycle sustained. Core write lands one cycle after handshake accept.
- Start: the start pulse follows the last write cycle by exactly one cycle.
- Readback: 3 cycles per word with `Ird_ready` held high (address, capture, present). The core's read data is valid the cycle after the address.
- Done to first `Ord_valid`: 3 cycles.
- `Igo` while busy has no effect. An `Igo` coinciding with the FINISH cycle is ignored.

## Structure
- `risc_host_pkg` holds the state enum, the `ADDR_W`/`DATA_W` defaults, and the core-port encoding constant `WRB_WRITE`=0.
- The timeout/RUN counter is a natural sub-module, `host_run_timer`: start, clear, expiry flag.
- Everything else stays in one module.

## Test plan
- Load the 16-word OR/AND/NOT program (0x78C0, 0x0040, …, 0x0001 HALT), plus data 0x00FF@64 and 0xFF00@65. Run with dump base 64, len 5. A behavioral core model must yield the stream 00FF, FF00, FFFF, 00FF, FF00.
- Core model that never asserts done → `Otimeout`=1 exactly TIMEOUT cycles after START, then a single `Odone` pulse with no `Ord_valid`.
- `Ird_ready` toggled 0/1 per cycle → `Ord_data` stays stable while stalled; no word is dropped or duplicated.
- Dump base 126, len 4 → `Ord_addr` sequence 126, 127, 0, 1.
- `Icpu_done` high before start, and `Idump_len`=0 → first done cycle ignored; `Odone` pulses with no readback.
- `Ireset_n` low during the LOAD write cycle → `Ocpu_access`=0 and `Obusy`=0 immediately. A fresh `Igo` after release runs a normal session.
